// File: rtl/instruction_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_loader_if
//   Narrow host-to-loader instruction stream (valid/ready with a last marker).
//   master : host side, drives s_tdata/s_tvalid/s_tlast, observes s_tready
//   slave  : loader side, observes the beat, drives s_tready
// Parameters
//   S_DATA_BITS  stream beat width
// ---------------------------------------------------------------------------
interface instruction_loader_if #(
    parameter int S_DATA_BITS = 32
);
    logic [S_DATA_BITS-1:0] s_tdata;
    logic                   s_tvalid;
    logic                   s_tlast;
    logic                   s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );
endinterface

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//   Write-side front end of the instruction buffer. Packs BEATS narrow stream
//   beats (first beat = least significant lane) into one instruction and
//   writes it to buffer port A at consecutive addresses starting from a base
//   latched with load_start. When the load ends it pulses load_done and,
//   if auto_kick was latched and no error occurred, pulses force_inst.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   load_start        begin a load (honoured only while idle)
//   load_base_addr    first write address, latched with load_start
//   auto_kick         latched with load_start; request force_inst at the end
//   s_axis            instruction stream (slave modport)
//   wea/addra/din     buffer port A write strobe, address, data
//   force_inst        one-cycle kick to the buffer
//   load_done         one-cycle completion pulse
//   load_count        instructions written in the current/last load
//   err_partial       sticky: last beat arrived mid-instruction
//   err_overflow      sticky: stream continued past the last buffer address
//
// Optional feature (macro LOADER_CHKSUM_EN)
//   Adds output chksum: XOR of every word written during the load, cleared
//   by an accepted load_start. Without the macro there is no port and no
//   accumulator.
// ---------------------------------------------------------------------------
module instruction_loader #(
    parameter int INST_BITS   = 128,
    parameter int S_DATA_BITS = 32,
    parameter int ADDR_BITS   = 10,
    parameter int PC_DEPTH    = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [ADDR_BITS-1:0]   load_base_addr,
    input  logic                   auto_kick,
    instruction_loader_if.slave    s_axis,
    output logic                   wea,
    output logic [ADDR_BITS-1:0]   addra,
    output logic [INST_BITS-1:0]   din,
    output logic                   force_inst,
    output logic                   load_done,
    output logic [ADDR_BITS:0]     load_count,
    output logic                   err_partial,
    output logic                   err_overflow
`ifdef LOADER_CHKSUM_EN
    ,
    output logic [INST_BITS-1:0]   chksum
`endif
);

    localparam int BEATS = INST_BITS / S_DATA_BITS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PC_DEPTH - 1);
    localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q;
    logic                   kick_q;
    logic [BW-1:0]          beat_cnt_q;
    logic                   last_q;         // instruction being assembled held s_tlast
    logic [ADDR_BITS:0]     load_count_q;
    logic                   err_partial_q;
    logic                   err_overflow_q;
    logic [S_DATA_BITS-1:0] lane_q [BEATS];

    logic                   tready;
    logic                   accept;
    logic                   start_ok;
    logic                   beat_full;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic                   at_end;

    assign tready    = (state_q == S_RECV);
    assign accept    = tready && s_axis.s_tvalid;
    assign start_ok  = (state_q == S_IDLE) && load_start;
    assign beat_full = (beat_cnt_q == LAST_BEAT);
    // Address arithmetic wraps modulo 2^ADDR_BITS.
    assign wr_addr   = base_q + load_count_q[ADDR_BITS-1:0];
    assign at_end    = (wr_addr == LAST_ADDR);

    assign s_axis.s_tready = tready;
    assign addra           = wr_addr;
    assign load_count      = load_count_q;
    assign err_partial     = err_partial_q;
    assign err_overflow    = err_overflow_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wea        = 1'b0;
        load_done  = 1'b0;
        force_inst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (accept && (beat_full || s_axis.s_tlast)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wea = 1'b1;
                // Writing the last buffer address without s_tlast ends the
                // load as an overflow; the remaining beats are never taken.
                if (last_q || at_end) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE: begin
                load_done  = 1'b1;
                force_inst = kick_q && !err_partial_q && !err_overflow_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q         <= '0;
            kick_q         <= 1'b0;
            beat_cnt_q     <= '0;
            last_q         <= 1'b0;
            load_count_q   <= '0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q         <= load_base_addr;
                kick_q         <= auto_kick;
                beat_cnt_q     <= '0;
                load_count_q   <= '0;
                err_partial_q  <= 1'b0;
                err_overflow_q <= 1'b0;
            end
            if (accept) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                last_q     <= s_axis.s_tlast;
                if (s_axis.s_tlast && !beat_full) begin
                    err_partial_q <= 1'b1;
                end
            end
            if (state_q == S_WRITE) begin
                beat_cnt_q   <= '0;
                load_count_q <= load_count_q + 1'b1;
                if (!last_q && at_end) begin
                    err_overflow_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction assembly: one register per lane. Beat 0 clears the upper
    // lanes so an early s_tlast leaves them zero-filled.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_q[gi] <= '0;
                end else if (accept) begin
                    if (beat_cnt_q == BW'(gi)) begin
                        lane_q[gi] <= s_axis.s_tdata;
                    end else if (beat_cnt_q == '0) begin
                        lane_q[gi] <= '0;
                    end
                end
            end
            assign din[gi*S_DATA_BITS +: S_DATA_BITS] = lane_q[gi];
        end
    endgenerate

`ifdef LOADER_CHKSUM_EN
    logic [INST_BITS-1:0] chksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chksum_q <= '0;
        end else if (start_ok) begin
            chksum_q <= '0;
        end else if (state_q == S_WRITE) begin
            chksum_q <= chksum_q ^ din;
        end
    end

    assign chksum = chksum_q;
`endif

endmodule
